// File: rtl/pipe_hazard_ctrl.sv
// Hazard/control pipeline for a 5-stage MIPS core: carries ID control through ID/EX, EX/MEM, MEM/WB.
// Latency: stage registers advance every edge; hazard, PC-select and forwarding outputs are combinational.
// Backpressure: load-use / JR-register stalls hold PC and IF/ID and inject an ID/EX bubble; a taken branch flushes.
module pipe_hazard_ctrl #(
   parameter int REG_W   = 5,
   parameter int ALUOP_W = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [ALUOP_W+8:0]   ID_Ctrl,
   input  logic                 ID_JR,
   input  logic [REG_W-1:0]     ID_Rs,
   input  logic [REG_W-1:0]     ID_Rt,
   input  logic [REG_W-1:0]     ID_Dst,
   input  logic                 EX_Zero,
   output logic                 PCWrite,
   output logic                 IFID_Write,
   output logic                 IFID_Flush,
   output logic [1:0]           PCSrc,
   output logic                 EX_ALUSrc,
   output logic [ALUOP_W-1:0]   EX_ALUOp,
   output logic                 MEM_MemRead,
   output logic                 MEM_MemWrite,
   output logic                 WB_MemtoReg,
   output logic                 WB_RegWrite,
   output logic [REG_W-1:0]     WB_Dst,
   output logic [1:0]           ForwardA,
   output logic [1:0]           ForwardB
);

   // Control word bit positions, ALUOp occupies the low ALUOP_W bits.
   localparam int CTRL_W   = ALUOP_W + 9;
   localparam int JUMP_B   = ALUOP_W + 8;
   localparam int REGDST_B = ALUOP_W + 7;
   localparam int ALUSRC_B = ALUOP_W + 6;
   localparam int MEM2R_B  = ALUOP_W + 5;
   localparam int REGWR_B  = ALUOP_W + 4;
   localparam int MEMRD_B  = ALUOP_W + 3;
   localparam int MEMWR_B  = ALUOP_W + 2;
   localparam int BNE_B    = ALUOP_W + 1;
   localparam int BEQ_B    = ALUOP_W;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_J   = 2'b10;
   localparam logic [1:0] PC_JR  = 2'b11;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b01;

   // ID/EX stage
   logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
   logic [REG_W-1:0]  ex_rs_q, ex_rs_d;
   logic [REG_W-1:0]  ex_rt_q, ex_rt_d;
   logic [REG_W-1:0]  ex_dst_q, ex_dst_d;
   // EX/MEM stage
   logic              mem_regwrite_q, mem_regwrite_d;
   logic              mem_memread_q, mem_memread_d;
   logic              mem_memwrite_q, mem_memwrite_d;
   logic              mem_memtoreg_q, mem_memtoreg_d;
   logic [REG_W-1:0]  mem_dst_q, mem_dst_d;
   // MEM/WB stage
   logic              wb_regwrite_q, wb_regwrite_d;
   logic              wb_memtoreg_q, wb_memtoreg_d;
   logic [REG_W-1:0]  wb_dst_q, wb_dst_d;

   logic br_taken;
   logic load_use;
   logic jr_wait;

   // Jump and RegDst are resolved in ID (PC select / ID_Dst); EX only carries them along.
   logic unused_ex_ctrl;
   assign unused_ex_ctrl = ex_ctrl_q[JUMP_B] ^ ex_ctrl_q[REGDST_B];

   // Hazard detection, priority resolution and ID/EX next value (bubble or ID word).
   always_comb begin
      br_taken = (ex_ctrl_q[BEQ_B] & EX_Zero) | (ex_ctrl_q[BNE_B] & ~EX_Zero);
      load_use = ex_ctrl_q[MEMRD_B] && (ex_dst_q != '0) &&
                 ((ex_dst_q == ID_Rs) || (ex_dst_q == ID_Rt));
      jr_wait  = ID_JR && (ID_Rs != '0) &&
                 ((ex_ctrl_q[REGWR_B] && (ex_dst_q == ID_Rs)) ||
                  (mem_regwrite_q && (mem_dst_q == ID_Rs)));

      PCWrite    = 1'b1;
      IFID_Write = 1'b1;
      IFID_Flush = 1'b0;
      PCSrc      = PC_SEQ;
      ex_ctrl_d  = ID_Ctrl;
      ex_rs_d    = ID_Rs;
      ex_rt_d    = ID_Rt;
      ex_dst_d   = ID_Dst;

      if (br_taken) begin
         // The branch resolves in EX: the ID instruction is wrong-path, so any stall or jump is moot.
         PCSrc      = PC_BR;
         IFID_Flush = 1'b1;
         ex_ctrl_d  = '0;
         ex_rs_d    = '0;
         ex_rt_d    = '0;
         ex_dst_d   = '0;
      end else if (load_use || jr_wait) begin
         PCWrite    = 1'b0;
         IFID_Write = 1'b0;
         ex_ctrl_d  = '0;
         ex_rs_d    = '0;
         ex_rt_d    = '0;
         ex_dst_d   = '0;
      end else if (ID_JR) begin
         PCSrc      = PC_JR;
         IFID_Flush = 1'b1;
      end else if (ID_Ctrl[JUMP_B]) begin
         // JAL keeps RegWrite so the link register still gets written.
         PCSrc      = PC_J;
         IFID_Flush = 1'b1;
      end
   end

   // EX/MEM and MEM/WB simply follow the stage ahead of them every cycle.
   always_comb begin
      mem_regwrite_d = ex_ctrl_q[REGWR_B];
      mem_memread_d  = ex_ctrl_q[MEMRD_B];
      mem_memwrite_d = ex_ctrl_q[MEMWR_B];
      mem_memtoreg_d = ex_ctrl_q[MEM2R_B];
      mem_dst_d      = ex_dst_q;
      wb_regwrite_d  = mem_regwrite_q;
      wb_memtoreg_d  = mem_memtoreg_q;
      wb_dst_d       = mem_dst_q;
   end

   // Stage registers, all cleared by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_ctrl_q      <= '0;
         ex_rs_q        <= '0;
         ex_rt_q        <= '0;
         ex_dst_q       <= '0;
         mem_regwrite_q <= 1'b0;
         mem_memread_q  <= 1'b0;
         mem_memwrite_q <= 1'b0;
         mem_memtoreg_q <= 1'b0;
         mem_dst_q      <= '0;
         wb_regwrite_q  <= 1'b0;
         wb_memtoreg_q  <= 1'b0;
         wb_dst_q       <= '0;
      end else begin
         ex_ctrl_q      <= ex_ctrl_d;
         ex_rs_q        <= ex_rs_d;
         ex_rt_q        <= ex_rt_d;
         ex_dst_q       <= ex_dst_d;
         mem_regwrite_q <= mem_regwrite_d;
         mem_memread_q  <= mem_memread_d;
         mem_memwrite_q <= mem_memwrite_d;
         mem_memtoreg_q <= mem_memtoreg_d;
         mem_dst_q      <= mem_dst_d;
         wb_regwrite_q  <= wb_regwrite_d;
         wb_memtoreg_q  <= wb_memtoreg_d;
         wb_dst_q       <= wb_dst_d;
      end
   end

   // Operand forwarding: the younger EX/MEM result wins over MEM/WB; $0 is never forwarded.
   always_comb begin
      ForwardA = FWD_RF;
      if (mem_regwrite_q && (mem_dst_q != '0) && (mem_dst_q == ex_rs_q)) begin
         ForwardA = FWD_MEM;
      end else if (wb_regwrite_q && (wb_dst_q != '0) && (wb_dst_q == ex_rs_q)) begin
         ForwardA = FWD_WB;
      end

      ForwardB = FWD_RF;
      if (mem_regwrite_q && (mem_dst_q != '0) && (mem_dst_q == ex_rt_q)) begin
         ForwardB = FWD_MEM;
      end else if (wb_regwrite_q && (wb_dst_q != '0) && (wb_dst_q == ex_rt_q)) begin
         ForwardB = FWD_WB;
      end
   end

   assign EX_ALUSrc    = ex_ctrl_q[ALUSRC_B];
   assign EX_ALUOp     = ex_ctrl_q[ALUOP_W-1:0];
   assign MEM_MemRead  = mem_memread_q;
   assign MEM_MemWrite = mem_memwrite_q;
   assign WB_MemtoReg  = wb_memtoreg_q;
   assign WB_RegWrite  = wb_regwrite_q;
   assign WB_Dst       = wb_dst_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed table-driven bench for pipe_hazard_ctrl: one table row per clock cycle.
// Inputs are driven after the falling edge, outputs sampled 1 time unit later.
// Extra hand-written sequences cover reset during reset hold and reset in the middle of a stall.
module tb_pipe_hazard_ctrl;

   localparam logic [12:0] C_NOP  = 13'h0000;
   localparam logic [12:0] C_LW   = 13'h0782;  // ALUSrc MemtoReg RegWrite MemRead, op 2
   localparam logic [12:0] C_ADD  = 13'h0901;  // RegDst RegWrite, op 1
   localparam logic [12:0] C_BQX  = 13'h0093;  // BranchEQ with MemRead set, op 3
   localparam logic [12:0] C_BEQ  = 13'h0013;  // BranchEQ, op 3
   localparam logic [12:0] C_J    = 13'h1000;
   localparam logic [12:0] C_JAL  = 13'h1100;
   localparam logic [12:0] C_ADDI = 13'h0505;  // ALUSrc RegWrite, op 5
   localparam logic [12:0] C_SW   = 13'h0442;  // ALUSrc MemWrite, op 2

   typedef struct packed {
      logic       pcw;
      logic       ifw;
      logic       fl;
      logic [1:0] src;
      logic       als;
      logic [3:0] aop;
      logic       mrd;
      logic       mwr;
      logic       wmtr;
      logic       wrw;
      logic [4:0] wdst;
      logic [1:0] fa;
      logic [1:0] fb;
   } out_t;

   typedef struct packed {
      logic [12:0] ctrl;
      logic        jr;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  dst;
      logic        zero;
      out_t        exp;
   } tv_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [12:0] ID_Ctrl;
   logic        ID_JR;
   logic [4:0]  ID_Rs, ID_Rt, ID_Dst;
   logic        EX_Zero;
   logic        PCWrite, IFID_Write, IFID_Flush;
   logic [1:0]  PCSrc;
   logic        EX_ALUSrc;
   logic [3:0]  EX_ALUOp;
   logic        MEM_MemRead, MEM_MemWrite, WB_MemtoReg, WB_RegWrite;
   logic [4:0]  WB_Dst;
   logic [1:0]  ForwardA, ForwardB;

   int n_checks = 0;
   int n_fail   = 0;
   tv_t tv[$];

   pipe_hazard_ctrl #(.REG_W(5), .ALUOP_W(4)) dut (
      .clk(clk), .reset(reset),
      .ID_Ctrl(ID_Ctrl), .ID_JR(ID_JR), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Dst(ID_Dst),
      .EX_Zero(EX_Zero),
      .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush), .PCSrc(PCSrc),
      .EX_ALUSrc(EX_ALUSrc), .EX_ALUOp(EX_ALUOp),
      .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
      .WB_MemtoReg(WB_MemtoReg), .WB_RegWrite(WB_RegWrite), .WB_Dst(WB_Dst),
      .ForwardA(ForwardA), .ForwardB(ForwardB)
   );

   always #5 clk = ~clk;

   function automatic tv_t vec(
      input logic [12:0] ctrl, input logic jr, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] dst, input logic zero,
      input logic pcw, input logic ifw, input logic fl, input logic [1:0] src,
      input logic als, input logic [3:0] aop, input logic mrd, input logic mwr,
      input logic wmtr, input logic wrw, input logic [4:0] wdst,
      input logic [1:0] fa, input logic [1:0] fb);
      tv_t t;
      t.ctrl = ctrl; t.jr = jr; t.rs = rs; t.rt = rt; t.dst = dst; t.zero = zero;
      t.exp.pcw = pcw; t.exp.ifw = ifw; t.exp.fl = fl; t.exp.src = src;
      t.exp.als = als; t.exp.aop = aop; t.exp.mrd = mrd; t.exp.mwr = mwr;
      t.exp.wmtr = wmtr; t.exp.wrw = wrw; t.exp.wdst = wdst; t.exp.fa = fa; t.exp.fb = fb;
      return t;
   endfunction

   task automatic chk(input string nm, input int row, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (step %0d): got %0h, expected %0h", nm, row, act, exp);
      end
   endtask

   task automatic check_all(input int row, input out_t e);
      chk("PCWrite",      row, 16'(PCWrite),      16'(e.pcw));
      chk("IFID_Write",   row, 16'(IFID_Write),   16'(e.ifw));
      chk("IFID_Flush",   row, 16'(IFID_Flush),   16'(e.fl));
      chk("PCSrc",        row, 16'(PCSrc),        16'(e.src));
      chk("EX_ALUSrc",    row, 16'(EX_ALUSrc),    16'(e.als));
      chk("EX_ALUOp",     row, 16'(EX_ALUOp),     16'(e.aop));
      chk("MEM_MemRead",  row, 16'(MEM_MemRead),  16'(e.mrd));
      chk("MEM_MemWrite", row, 16'(MEM_MemWrite), 16'(e.mwr));
      chk("WB_MemtoReg",  row, 16'(WB_MemtoReg),  16'(e.wmtr));
      chk("WB_RegWrite",  row, 16'(WB_RegWrite),  16'(e.wrw));
      chk("WB_Dst",       row, 16'(WB_Dst),       16'(e.wdst));
      chk("ForwardA",     row, 16'(ForwardA),     16'(e.fa));
      chk("ForwardB",     row, 16'(ForwardB),     16'(e.fb));
   endtask

   task automatic drive(input logic [12:0] ctrl, input logic jr, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] dst, input logic zero);
      ID_Ctrl = ctrl; ID_JR = jr; ID_Rs = rs; ID_Rt = rt; ID_Dst = dst; EX_Zero = zero;
   endtask

   initial begin
      out_t idle;
      idle = '{pcw:1'b1, ifw:1'b1, default:'0};

      //          ctrl    jr rs  rt  dst z | pcw ifw fl src  als aop mrd mwr wmtr wrw wdst fa  fb
      // power-up idle
      tv.push_back(vec(C_NOP, 0, 0, 0, 0, 0,   1, 1, 0, 2'd0, 0, 4'd0, 0, 0, 0, 0, 5'd0,  2'd0, 2'd0));
      tv.push_back(vec(C_NOP, 0, 0, 0, 0, 0,   1, 1, 0, 2'd0, 0, 4'd0, 0, 0, 0, 0, 5'd0,  2'd0, 2'd0));
      tv.push_back(vec(C_NOP, 0, 0, 0, 0, 0,   1, 1, 0, 2'd0, 0, 4'd0, 0, 0, 0, 0, 5'd0,  2'd0, 2'd0));
      // LW $8 then consumer of $8: one stall cycle, bubble visible in EX next cycle
      tv.push_back(vec(C_LW,  0, 1, 8, 8, 0,   1, 1, 0, 2'd0, 0, 4'd0, 0, 0, 0, 0, 5'd0,  2'd0, 2'd0));
      tv.push_back(vec(C_ADD, 0, 8, 2, 3, 0,   0, 0, 0, 2'd0, 1, 4'd2, 0, 0, 0, 0, 5'd0,  2'd0, 2'd0));
      tv.push_back(vec(C_ADD, 0, 8, 2, 3, 0,   1, 1, 0, 2'd0, 0, 4'd0, 1, 0, 0, 0, 5'd0,  2'd0, 2'd0));
      // consumer reaches EX with the load in WB -> MEM/WB forward on A
      tv.push_back(vec(C_ADD, 0, 4, 5, 9, 0,   1, 1, 0, 2'd0, 0, 4'd1, 0, 0, 1, 1, 5'd8,  2'd1, 2'd0));
      tv.push_back(vec(C_ADD, 0, 6, 7, 9, 0,   1, 1, 0, 2'd0, 0, 4'd1, 0, 0, 0, 0, 5'd0,  2'd0, 2'd0));
      tv.push_back(vec(C_ADD, 0, 9, 9,10, 0,   1, 1, 0, 2'd0, 0, 4'd1, 0, 0, 0, 1, 5'd3,  2'd0, 2'd0));
      // both MEM and WB hold $9: MEM wins on both operands
      tv.push_back(vec(C_NOP, 0, 0, 0, 0, 0,   1, 1, 0, 2'd0, 0, 4'd1, 0, 0, 0, 1, 5'd9,  2'd2, 2'd2));
      tv.push_back(vec(C_NOP, 0, 0, 0, 0, 0,   1, 1, 0, 2'd0, 0, 4'd0, 0, 0, 0, 1, 5'd9,  2'd0, 2'd0));
      // same pattern targeting $0: never forwarded
      tv.push_back(vec(C_ADD, 0, 1, 1, 0, 0,   1, 1, 0, 2'd0, 0, 4'd0, 0, 0, 0, 1, 5'd10, 2'd0, 2'd0));
      tv.push_back(vec(C_ADD, 0, 1, 1, 0, 0,   1, 1, 0, 2'd0, 0, 4'd1, 0, 0, 0, 0, 5'd0,  2'd0, 2'd0));
      tv.push_back(vec(C_ADD, 0, 0, 0,11, 0,   1, 1, 0, 2'd0, 0, 4'd1, 0, 0, 0, 0, 5'd0,  2'd0, 2'd0));
      tv.push_back(vec(C_NOP, 0, 0, 0, 0, 0,   1, 1, 0, 2'd0, 0, 4'd1, 0, 0, 0, 1, 5'd0,  2'd0, 2'd0));
      tv.push_back(vec(C_NOP, 0, 0, 0, 0, 0,   1, 1, 0, 2'd0, 0, 4'd0, 0, 0, 0, 1, 5'd0,  2'd0, 2'd0));
      // taken branch in EX beats a J and a load-use match in ID
      tv.push_back(vec(C_BQX, 0, 1, 2, 5, 0,   1, 1, 0, 2'd0, 0, 4'd0, 0, 0, 0, 1, 5'd11, 2'd0, 2'd0));
      tv.push_back(vec(C_J,   0, 5, 0, 0, 1,   1, 1, 1, 2'd1, 0, 4'd3, 0, 0, 0, 0, 5'd0,  2'd0, 2'd0));
      tv.push_back(vec(C_NOP, 0, 0, 0, 0, 1,   1, 1, 0, 2'd0, 0, 4'd0, 1, 0, 0, 0, 5'd0,  2'd0, 2'd0));
      // not-taken branch: J in ID proceeds, then JAL
      tv.push_back(vec(C_BEQ, 0, 1, 2, 0, 0,   1, 1, 0, 2'd0, 0, 4'd0, 0, 0, 0, 0, 5'd5,  2'd0, 2'd0));
      tv.push_back(vec(C_J,   0, 0, 0, 0, 0,   1, 1, 1, 2'd2, 0, 4'd3, 0, 0, 0, 0, 5'd0,  2'd0, 2'd0));
      tv.push_back(vec(C_JAL, 0, 0, 0,31, 0,   1, 1, 1, 2'd2, 0, 4'd0, 0, 0, 0, 0, 5'd0,  2'd0, 2'd0));
      tv.push_back(vec(C_NOP, 0, 0, 0, 0, 0,   1, 1, 0, 2'd0, 0, 4'd0, 0, 0, 0, 0, 5'd0,  2'd0, 2'd0));
      tv.push_back(vec(C_NOP, 0, 0, 0, 0, 0,   1, 1, 0, 2'd0, 0, 4'd0, 0, 0, 0, 0, 5'd0,  2'd0, 2'd0));
      tv.push_back(vec(C_NOP, 0, 0, 0, 0, 0,   1, 1, 0, 2'd0, 0, 4'd0, 0, 0, 0, 1, 5'd31, 2'd0, 2'd0));
      // ADDI $31 then JR $31: EX-match stall, MEM-match stall, then jump
      tv.push_back(vec(C_ADDI,0, 0,31,31, 0,   1, 1, 0, 2'd0, 0, 4'd0, 0, 0, 0, 0, 5'd0,  2'd0, 2'd0));
      tv.push_back(vec(C_NOP, 1,31, 0, 0, 0,   0, 0, 0, 2'd0, 1, 4'd5, 0, 0, 0, 0, 5'd0,  2'd0, 2'd0));
      tv.push_back(vec(C_NOP, 1,31, 0, 0, 0,   0, 0, 0, 2'd0, 0, 4'd0, 0, 0, 0, 0, 5'd0,  2'd0, 2'd0));
      tv.push_back(vec(C_NOP, 1,31, 0, 0, 0,   1, 1, 1, 2'd3, 0, 4'd0, 0, 0, 0, 1, 5'd31, 2'd0, 2'd0));
      tv.push_back(vec(C_NOP, 0, 0, 0, 0, 0,   1, 1, 0, 2'd0, 0, 4'd0, 0, 0, 0, 0, 5'd0,  2'd0, 2'd0));
      // store reaches MEM with MemWrite
      tv.push_back(vec(C_SW,  0, 1, 2, 0, 0,   1, 1, 0, 2'd0, 0, 4'd0, 0, 0, 0, 0, 5'd0,  2'd0, 2'd0));
      tv.push_back(vec(C_NOP, 0, 0, 0, 0, 0,   1, 1, 0, 2'd0, 1, 4'd2, 0, 0, 0, 0, 5'd0,  2'd0, 2'd0));
      tv.push_back(vec(C_NOP, 0, 0, 0, 0, 0,   1, 1, 0, 2'd0, 0, 4'd0, 0, 1, 0, 0, 5'd0,  2'd0, 2'd0));

      // Reset held low: stage outputs cleared, fetch enabled.
      reset = 1'b0;
      drive(C_NOP, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      #1;
      check_all(-1, idle);
      reset = 1'b1;

      // Main table, one row per cycle.
      for (int i = 0; i < tv.size(); i++) begin
         @(negedge clk);
         drive(tv[i].ctrl, tv[i].jr, tv[i].rs, tv[i].rt, tv[i].dst, tv[i].zero);
         #1;
         check_all(i, tv[i].exp);
      end

      // Reset asserted in the middle of a load-use stall.
      @(negedge clk);
      drive(C_LW, 0, 1, 8, 8, 0);
      @(negedge clk);
      drive(C_ADD, 0, 8, 2, 3, 0);
      #1;
      chk("stall_before_reset_PCWrite", 100, 16'(PCWrite), 16'd0);
      reset = 1'b0;
      #1;
      chk("reset_mid_stall_PCWrite",    101, 16'(PCWrite),    16'd1);
      chk("reset_mid_stall_IFID_Write", 101, 16'(IFID_Write), 16'd1);
      chk("reset_mid_stall_EX_ALUOp",   101, 16'(EX_ALUOp),   16'd0);
      chk("reset_mid_stall_EX_ALUSrc",  101, 16'(EX_ALUSrc),  16'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("post_reset_PCWrite",     102, 16'(PCWrite),     16'd1);
      chk("post_reset_IFID_Flush",  102, 16'(IFID_Flush),  16'd0);
      chk("post_reset_PCSrc",       102, 16'(PCSrc),       16'd0);
      chk("post_reset_MEM_MemRead", 102, 16'(MEM_MemRead), 16'd0);
      @(negedge clk);
      drive(C_NOP, 0, 0, 0, 0, 0);
      #1;
      chk("post_reset_advance_EX_ALUOp", 103, 16'(EX_ALUOp),    16'd1);
      chk("post_reset_advance_MemRead",  103, 16'(MEM_MemRead), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
